// File: rtl/traffic_timebase.sv
// traffic_timebase: 0..99 cycle timer with tick/wrap pulses and free-running 25%/12.5% dimming PWM
module traffic_timebase #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 10,
    parameter int PWM_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clr,
    output logic [6:0] ten_secs,
    output logic       tick,
    output logic       cycle_wrap,
    output logic       pwm_25,
    output logic       pwm_12p5
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = PWM_DIV > 1 ? $clog2(PWM_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(PWM_DIV - 1);
    localparam logic [6:0] TEN_LAST = 7'd99;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [6:0]    ten_q, ten_d;
    logic          tick_q, tick_d, wrap_q, wrap_d, tick_ev;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    ph_q, ph_d;
    logic          p25_q, p12_q;
    // clr wins over a coincident tick; run=0 freezes prescaler and position
    always_comb begin
        tick_ev   = run && !clr && pre_cnt_q == PRE_LAST;
        pre_cnt_d = clr ? '0 : !run ? pre_cnt_q : pre_cnt_q == PRE_LAST ? '0 : pre_cnt_q + PW'(1);
        ten_d     = clr ? 7'd0 : !tick_ev ? ten_q : ten_q == TEN_LAST ? 7'd0 : ten_q + 7'd1;
        tick_d    = tick_ev;
        wrap_d    = tick_ev && ten_q == TEN_LAST;
        div_d     = div_q == DIV_LAST ? '0 : div_q + DW'(1);
        ph_d      = div_q == DIV_LAST ? ph_q + 3'd1 : ph_q;
    end
    // cycle timer state and its registered pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            ten_q     <= 7'd0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            ten_q     <= ten_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
        end
    end
    // PWM phase generator runs regardless of run/clr; outputs lag ph by one clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            ph_q  <= 3'd0;
            p25_q <= 1'b0;
            p12_q <= 1'b0;
        end else begin
            div_q <= div_d;
            ph_q  <= ph_d;
            p25_q <= ph_q < 3'd2;
            p12_q <= ph_q == 3'd0;
        end
    end
    assign ten_secs   = ten_q;
    assign tick       = tick_q;
    assign cycle_wrap = wrap_q;
    assign pwm_25     = p25_q;
    assign pwm_12p5   = p12_q;
endmodule

// File: tb/tb_traffic_timebase.sv
// tb_traffic_timebase: directed checks of the cycle timer, clear/hold behaviour, PWM and async reset
module tb_traffic_timebase;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       clr = 1'b0;
    logic [6:0] ten_secs;
    logic       tick, cycle_wrap, pwm_25, pwm_12p5;
    int total = 0;
    int bad = 0;

    traffic_timebase #(.CLK_HZ(20), .TICK_HZ(2), .PWM_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .clr(clr),
        .ten_secs(ten_secs), .tick(tick), .cycle_wrap(cycle_wrap),
        .pwm_25(pwm_25), .pwm_12p5(pwm_12p5)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        clr = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total++;
        if ({ten_secs, tick, cycle_wrap, pwm_25, pwm_12p5} !== 11'd0) begin
            bad++;
            $display("FAIL reset_state: got ten=%0d tick=%b wrap=%b p25=%b p12=%b want all 0", ten_secs, tick, cycle_wrap, pwm_25, pwm_12p5);
        end
        rst_n = 1'b1;
        run = 1'b1;
        step();
        total++;
        if (pwm_25 !== 1'b1 || pwm_12p5 !== 1'b1) begin
            bad++;
            $display("FAIL pwm_first_edge: got p25=%b p12=%b want 1 1", pwm_25, pwm_12p5);
        end
    endtask

    task automatic test_tick();
        logic [6:0] exp_ten;
        do_reset();
        run = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            step();
            exp_ten = 7'(k / 10);
            total++;
            if (tick !== (k % 10 == 0) || ten_secs !== exp_ten) begin
                bad++;
                $display("FAIL tick_cadence k=%0d: got tick=%b ten=%0d want tick=%b ten=%0d", k, tick, ten_secs, k % 10 == 0, exp_ten);
            end
        end
    endtask

    task automatic test_wrap();
        logic [6:0] exp_ten;
        int wraps;
        wraps = 0;
        do_reset();
        run = 1'b1;
        for (int k = 1; k <= 1000; k++) begin
            step();
            exp_ten = 7'((k / 10) % 100);
            if (cycle_wrap === 1'b1) wraps++;
            total++;
            if (ten_secs !== exp_ten || cycle_wrap !== (k == 1000)) begin
                bad++;
                $display("FAIL wrap_seq k=%0d: got ten=%0d wrap=%b want ten=%0d wrap=%b", k, ten_secs, cycle_wrap, exp_ten, k == 1000);
            end
        end
        total++;
        if (tick !== 1'b1) begin
            bad++;
            $display("FAIL wrap_tick: got tick=%b want 1", tick);
        end
        total++;
        if (wraps != 1) begin
            bad++;
            $display("FAIL wrap_count: got %0d want 1", wraps);
        end
    endtask

    task automatic test_hold();
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 6; k++) step();
        run = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            step();
            total++;
            if (tick !== 1'b0 || ten_secs !== 7'd0) begin
                bad++;
                $display("FAIL hold k=%0d: got tick=%b ten=%0d want 0 0", k, tick, ten_secs);
            end
        end
        run = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            step();
            total++;
            if (tick !== (s == 4)) begin
                bad++;
                $display("FAIL resume s=%0d: got tick=%b want %b", s, tick, s == 4);
            end
        end
        total++;
        if (ten_secs !== 7'd1) begin
            bad++;
            $display("FAIL resume_ten: got %0d want 1", ten_secs);
        end
    endtask

    task automatic test_clr();
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 579; k++) step();
        total++;
        if (ten_secs !== 7'd57) begin
            bad++;
            $display("FAIL clr_setup: got ten=%0d want 57", ten_secs);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++;
        if (ten_secs !== 7'd0 || tick !== 1'b0 || cycle_wrap !== 1'b0) begin
            bad++;
            $display("FAIL clr_priority: got ten=%0d tick=%b wrap=%b want 0 0 0", ten_secs, tick, cycle_wrap);
        end
        for (int s = 1; s <= 10; s++) begin
            step();
            total++;
            if (tick !== (s == 10) || ten_secs !== ((s == 10) ? 7'd1 : 7'd0)) begin
                bad++;
                $display("FAIL clr_restart s=%0d: got tick=%b ten=%0d want tick=%b", s, tick, ten_secs, s == 10);
            end
        end
    endtask

    task automatic test_pwm();
        int h25, h12;
        logic e25, e12;
        h25 = 0;
        h12 = 0;
        do_reset();
        for (int k = 1; k <= 64; k++) begin
            run = !(k >= 20 && k < 40);
            clr = (k == 30 || k == 50);
            step();
            e25 = (k % 16 >= 1 && k % 16 <= 4);
            e12 = (k % 16 >= 1 && k % 16 <= 2);
            if (pwm_25 === 1'b1) h25++;
            if (pwm_12p5 === 1'b1) h12++;
            total++;
            if (pwm_25 !== e25 || pwm_12p5 !== e12) begin
                bad++;
                $display("FAIL pwm_wave k=%0d: got p25=%b p12=%b want %b %b", k, pwm_25, pwm_12p5, e25, e12);
            end
        end
        clr = 1'b0;
        total++;
        if (h25 != 16 || h12 != 8) begin
            bad++;
            $display("FAIL pwm_duty: got high25=%0d high12=%0d want 16 8", h25, h12);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 420; k++) step();
        total++;
        if (ten_secs !== 7'd42) begin
            bad++;
            $display("FAIL async_setup: got ten=%0d want 42", ten_secs);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({ten_secs, tick, cycle_wrap, pwm_25, pwm_12p5} !== 11'd0) begin
            bad++;
            $display("FAIL async_reset: got ten=%0d tick=%b wrap=%b p25=%b p12=%b want all 0", ten_secs, tick, cycle_wrap, pwm_25, pwm_12p5);
        end
        rst_n = 1'b1;
        for (int s = 1; s <= 10; s++) begin
            step();
            total++;
            if (tick !== (s == 10) || ten_secs !== ((s == 10) ? 7'd1 : 7'd0)) begin
                bad++;
                $display("FAIL async_restart s=%0d: got tick=%b ten=%0d want tick=%b", s, tick, ten_secs, s == 10);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_wrap();
        test_hold();
        test_clr();
        test_pwm();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
